product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Downstream consumer of the 4-bit combinational multiplier.
- Accepts a stream of 8-bit products through a valid/ready handshake and sums a programmed number of them into a wider accumulator, forming a dot-product/MAC result.
- Presents the finished sum on a valid/ready output port.
- Sits between the multiplier array and the result register/bus interface.

Parameters:
- PROD_W, 8, width of incoming product (matches 4x4 multiplier output)
- ACC_W, 16, accumulator and result width; must be >= PROD_W
- LEN_W, 4, width of the job length field (max products per job = 2^LEN_W - 1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin job; sampled only in IDLE
- len  in  LEN_W  number of products in job; sampled with start
- in_valid  in  1  product valid
- in_ready  out  1  accumulator can take product
- product  in  PROD_W  unsigned product from multiplier
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- acc_out  out  ACC_W  accumulated result
- overflow  out  1  sticky: job exceeded ACC_W range
- busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: async on rst_n low, state=IDLE; acc_out, remaining count, overflow, in_ready, out_valid and busy all 0. Reset mid-job aborts the job with no output produced.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start=1: clear acc and overflow, latch len into remaining.
  - Next state is ACCUM if len!=0, else DONE (acc_out=0, out_valid the following cycle).
- ACCUM:
  - in_ready=1 and busy=1.
  - Transfer occurs when in_valid&&in_ready. On a transfer: acc <= acc + zero-extended product; remaining <= remaining-1.
  - Cycles with in_valid=0 leave state unchanged; there is no timeout.
  - When the transfer has remaining==1, next state is DONE.
  - in_ready drops in the cycle after the final transfer, so no extra product is accepted.
- DONE:
  - out_valid=1; acc_out and overflow are held stable while out_valid=1 && out_ready=0.
  - On out_ready=1: next state IDLE and out_valid deasserts the next cycle.
  - acc_out keeps its last value in IDLE until the next start.
- start outside IDLE is ignored, with no effect on acc or len.
- Latency: out_valid rises exactly 1 cycle after the clock edge of the final transfer. Back-to-back jobs are possible: start may be asserted in the IDLE cycle immediately following the out handshake.
- Arithmetic: unsigned. Sum computed at ACC_W+1 bits; carry-out sets overflow (sticky until next start). Without the optional feature the sum wraps mod 2^ACC_W.
- product is not registered internally; the upstream holds it stable while in_valid=1 && in_ready=0.

Optional Feature:
- Macro: PRODUCT_ACCUMULATOR_SATURATE_EN.
- Defined: on carry-out, acc is clamped to all ones (2^ACC_W-1) and stays there for the rest of the job; overflow is still set.
- Undefined: wrap-around addition; overflow flag only.

Test Plan:
- start, len=3; products 225,225,225 with in_valid continuous -> out_valid 1 cycle after 3rd transfer, acc_out=675, overflow=0, exactly 3 transfers with in_ready high.
- start, len=0 -> DONE next cycle, out_valid=1, acc_out=0, no transfer occurs (in_ready stays 0).
- len=2, products 10 and 20 with in_valid gaps of 3 cycles; out_ready held low 5 cycles -> acc_out=30 held stable, out_valid held until out_ready=1, then busy=0 next cycle.
- ACC_W=8, len=2, products 200 and 100:
  - without macro -> acc_out=44, overflow=1.
  - with PRODUCT_ACCUMULATOR_SATURATE_EN -> acc_out=255, overflow=1.
- start pulsed during ACCUM with len=7 (job len=2) -> ignored; job completes after 2 transfers.
- rst_n low asynchronously mid-ACCUM (between clock edges) -> outputs 0 immediately; after release the next job (len=1, product 9) yields acc_out=9.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator
// Sums a programmed number of unsigned products from the multiplier array into
// a wider accumulator. Products arrive over a valid/ready handshake, and the
// finished sum leaves over a second valid/ready handshake.
//
// Build option: define PRODUCT_ACCUMULATOR_SATURATE_EN to make the accumulator
// clamp to all ones on carry-out. When it is undefined, the sum wraps around.
// The sticky overflow flag is raised in both builds.
module product_accumulator #(
   parameter int PROD_W = 8,
   parameter int ACC_W  = 16,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] product,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              overflow,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

   state_t             state_r;
   logic [LEN_W-1:0]   remaining_r;
   logic [ACC_W:0]     sum_s;
   logic [ACC_W-1:0]   acc_next_s;
   logic               carry_s;
   logic               xfer_s;

   // Unsigned add one guard bit wider than the accumulator.
   // The top bit of the result is the carry-out.
   function automatic logic [ACC_W:0] add_with_carry(
      input logic [ACC_W-1:0]  a,
      input logic [PROD_W-1:0] b
   );
      logic [ACC_W:0] b_ext;
      b_ext             = {(ACC_W+1){1'b0}};
      b_ext[PROD_W-1:0] = b;
      return {1'b0, a} + b_ext;
   endfunction

   // Form the candidate accumulator value and the carry for the current product.
   always_comb begin
      sum_s   = add_with_carry(acc_out, product);
      carry_s = sum_s[ACC_W];
      xfer_s  = in_valid && in_ready;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
      // After the first clamp the accumulator is all ones. Any further
      // non-zero product carries out again, so the value stays clamped.
      if (carry_s) begin
         acc_next_s = {ACC_W{1'b1}};
      end else begin
         acc_next_s = sum_s[ACC_W-1:0];
      end
`else
      acc_next_s = sum_s[ACC_W-1:0];
`endif
   end

   // Job control FSM.
   // All handshake and status outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         remaining_r <= LEN_ZERO;
         acc_out     <= {ACC_W{1'b0}};
         overflow    <= 1'b0;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  acc_out     <= {ACC_W{1'b0}};
                  overflow    <= 1'b0;
                  remaining_r <= len;
                  busy        <= 1'b1;
                  if (len != LEN_ZERO) begin
                     state_r  <= ST_ACCUM;
                     in_ready <= 1'b1;
                  end else begin
                     // An empty job reports a zero sum on the next cycle.
                     state_r   <= ST_DONE;
                     out_valid <= 1'b1;
                  end
               end else begin
                  // The last result stays visible on acc_out while idle.
                  state_r <= ST_IDLE;
               end
            end

            ST_ACCUM: begin
               if (xfer_s) begin
                  acc_out     <= acc_next_s;
                  overflow    <= overflow | carry_s;
                  remaining_r <= remaining_r - LEN_ONE;
                  if (remaining_r == LEN_ONE) begin
                     // Drop in_ready on the final transfer so that no
                     // extra product is accepted.
                     state_r   <= ST_DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     state_r <= ST_ACCUM;
                  end
               end else begin
                  // No timeout: wait for the upstream as long as it takes.
                  state_r <= ST_ACCUM;
               end
            end

            ST_DONE: begin
               if (out_ready) begin
                  state_r   <= ST_IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end else begin
                  // Hold the result and the flags until the consumer accepts them.
                  state_r <= ST_DONE;
               end
            end

            default: begin
               state_r     <= ST_IDLE;
               remaining_r <= LEN_ZERO;
               in_ready    <= 1'b0;
               out_valid   <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed testbench for product_accumulator.
// It uses a default instance with ACC_W=16 and a narrow instance with ACC_W=8
// for the overflow case.
module tb_product_accumulator;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] len;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] product;
   logic       out_valid;
   logic       out_ready;
   logic [15:0] acc_out;
   logic       overflow;
   logic       busy;

   logic       start8;
   logic [3:0] len8;
   logic       in_valid8;
   logic       in_ready8;
   logic [7:0] product8;
   logic       out_valid8;
   logic       out_ready8;
   logic [7:0] acc_out8;
   logic       overflow8;
   logic       busy8;

   int n_checks;
   int n_pass;

   product_accumulator dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready), .product(product),
      .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
      .overflow(overflow), .busy(busy)
   );

   product_accumulator #(.PROD_W(8), .ACC_W(8), .LEN_W(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .len(len8),
      .in_valid(in_valid8), .in_ready(in_ready8), .product(product8),
      .out_valid(out_valid8), .out_ready(out_ready8), .acc_out(acc_out8),
      .overflow(overflow8), .busy(busy8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle. Return 1 time unit after the active edge so that
   // outputs are sampled and inputs driven away from the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0; len = 4'd0; in_valid = 1'b0; product = 8'd0; out_ready = 1'b0;
      start8 = 1'b0; len8 = 4'd0; in_valid8 = 1'b0; product8 = 8'd0; out_ready8 = 1'b0;
      #12;
      n_checks++;
      if ({in_ready, out_valid, busy, overflow, acc_out} !== 20'd0)
         $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b ovf=%b acc=%0d, want all 0",
                  in_ready, out_valid, busy, overflow, acc_out);
      else n_pass++;
      n_checks++;
      if ({in_ready8, out_valid8, busy8, overflow8, acc_out8} !== 12'd0)
         $display("FAIL reset_outputs8: got rdy=%b vld=%b busy=%b ovf=%b acc=%0d, want all 0",
                  in_ready8, out_valid8, busy8, overflow8, acc_out8);
      else n_pass++;
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_basic();
      int cnt;
      start = 1'b1; len = 4'd3;
      cyc();
      start = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1)
         $display("FAIL basic_accum_entry: got rdy=%b busy=%b, want 1 1", in_ready, busy);
      else n_pass++;
      in_valid = 1'b1; product = 8'd225;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         logic xfer;
         xfer = in_ready && in_valid;
         cyc();
         if (xfer) cnt++;
         if (cnt == 2) begin
            n_checks++;
            if (out_valid !== 1'b0)
               $display("FAIL basic_early_valid: got out_valid=%b, want 0", out_valid);
            else n_pass++;
         end
         if (cnt == 3) break;
      end
      n_checks++;
      if (cnt !== 3) $display("FAIL basic_xfer_count: got %0d, want 3", cnt);
      else n_pass++;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0)
         $display("FAIL basic_done: got vld=%b rdy=%b, want 1 0", out_valid, in_ready);
      else n_pass++;
      n_checks++;
      if (acc_out !== 16'd675 || overflow !== 1'b0)
         $display("FAIL basic_sum: got acc=%0d ovf=%b, want 675 0", acc_out, overflow);
      else n_pass++;
      // in_valid stays high one extra cycle; no fourth product may be taken.
      cyc();
      n_checks++;
      if (acc_out !== 16'd675 || out_valid !== 1'b1)
         $display("FAIL basic_no_extra: got acc=%0d vld=%b, want 675 1", acc_out, out_valid);
      else n_pass++;
      in_valid = 1'b0; out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || acc_out !== 16'd675)
         $display("FAIL basic_handshake: got vld=%b busy=%b acc=%0d, want 0 0 675",
                  out_valid, busy, acc_out);
      else n_pass++;
   endtask

   task automatic test_len_zero();
      // This start lands in the IDLE cycle right after the previous handshake.
      start = 1'b1; len = 4'd0; in_valid = 1'b1; product = 8'd99;
      cyc();
      start = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || acc_out !== 16'd0 || in_ready !== 1'b0 || busy !== 1'b1)
         $display("FAIL len0_done: got vld=%b acc=%0d rdy=%b busy=%b, want 1 0 0 1",
                  out_valid, acc_out, in_ready, busy);
      else n_pass++;
      cyc();
      n_checks++;
      if (acc_out !== 16'd0 || in_ready !== 1'b0)
         $display("FAIL len0_no_xfer: got acc=%0d rdy=%b, want 0 0", acc_out, in_ready);
      else n_pass++;
      in_valid = 1'b0; out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL len0_release: got vld=%b busy=%b, want 0 0", out_valid, busy);
      else n_pass++;
   endtask

   task automatic test_stall();
      logic stable;
      start = 1'b1; len = 4'd2;
      cyc();
      start = 1'b0;
      repeat (3) cyc();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc_out !== 16'd0)
         $display("FAIL stall_gap: got rdy=%b vld=%b acc=%0d, want 1 0 0",
                  in_ready, out_valid, acc_out);
      else n_pass++;
      in_valid = 1'b1; product = 8'd10;
      cyc();
      in_valid = 1'b0; product = 8'd77;
      repeat (3) cyc();
      n_checks++;
      if (acc_out !== 16'd10 || out_valid !== 1'b0)
         $display("FAIL stall_partial: got acc=%0d vld=%b, want 10 0", acc_out, out_valid);
      else n_pass++;
      in_valid = 1'b1; product = 8'd20;
      cyc();
      in_valid = 1'b0;
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (out_valid !== 1'b1 || acc_out !== 16'd30 || busy !== 1'b1) stable = 1'b0;
         cyc();
      end
      n_checks++;
      if (stable !== 1'b1)
         $display("FAIL stall_hold: got held=%b (acc=%0d vld=%b), want held=1 acc=30 vld=1",
                  stable, acc_out, out_valid);
      else n_pass++;
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || acc_out !== 16'd30)
         $display("FAIL stall_release: got busy=%b vld=%b acc=%0d, want 0 0 30",
                  busy, out_valid, acc_out);
      else n_pass++;
   endtask

   task automatic test_overflow();
      logic [7:0] exp_acc;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
      exp_acc = 8'd255;
`else
      exp_acc = 8'd44;
`endif
      start8 = 1'b1; len8 = 4'd2;
      cyc();
      start8 = 1'b0; in_valid8 = 1'b1; product8 = 8'd200;
      cyc();
      n_checks++;
      if (overflow8 !== 1'b0 || acc_out8 !== 8'd200)
         $display("FAIL ovf_first: got acc=%0d ovf=%b, want 200 0", acc_out8, overflow8);
      else n_pass++;
      product8 = 8'd100;
      cyc();
      in_valid8 = 1'b0;
      n_checks++;
      if (out_valid8 !== 1'b1 || acc_out8 !== exp_acc || overflow8 !== 1'b1)
         $display("FAIL ovf_result: got vld=%b acc=%0d ovf=%b, want 1 %0d 1",
                  out_valid8, acc_out8, overflow8, exp_acc);
      else n_pass++;
      out_ready8 = 1'b1;
      cyc();
      out_ready8 = 1'b0;
      n_checks++;
      if (overflow8 !== 1'b1 || out_valid8 !== 1'b0)
         $display("FAIL ovf_sticky: got ovf=%b vld=%b, want 1 0", overflow8, out_valid8);
      else n_pass++;
   endtask

   task automatic test_start_ignored();
      start = 1'b1; len = 4'd2;
      cyc();
      len = 4'd7;
      in_valid = 1'b1; product = 8'd5;
      cyc();
      product = 8'd6;
      cyc();
      n_checks++;
      if (out_valid !== 1'b1 || acc_out !== 16'd11 || in_ready !== 1'b0)
         $display("FAIL ign_done: got vld=%b acc=%0d rdy=%b, want 1 11 0",
                  out_valid, acc_out, in_ready);
      else n_pass++;
      cyc();
      n_checks++;
      if (out_valid !== 1'b1 || acc_out !== 16'd11)
         $display("FAIL ign_in_done: got vld=%b acc=%0d, want 1 11", out_valid, acc_out);
      else n_pass++;
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0)
         $display("FAIL ign_release: got busy=%b vld=%b, want 0 0", busy, out_valid);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      int waited;
      start = 1'b1; len = 4'd3;
      cyc();
      start = 1'b0; in_valid = 1'b1; product = 8'd50;
      cyc();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({in_ready, out_valid, busy, overflow, acc_out} !== 20'd0)
         $display("FAIL areset_now: got rdy=%b vld=%b busy=%b ovf=%b acc=%0d, want all 0",
                  in_ready, out_valid, busy, overflow, acc_out);
      else n_pass++;
      #1;
      rst_n = 1'b1;
      cyc();
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0)
         $display("FAIL areset_aborted: got busy=%b vld=%b, want 0 0", busy, out_valid);
      else n_pass++;
      start = 1'b1; len = 4'd1;
      cyc();
      start = 1'b0; in_valid = 1'b1; product = 8'd9;
      waited = 0;
      cyc();
      in_valid = 1'b0;
      while (out_valid !== 1'b1 && waited < 20) begin
         cyc();
         waited++;
      end
      n_checks++;
      if (out_valid !== 1'b1 || waited !== 0 || acc_out !== 16'd9)
         $display("FAIL areset_next_job: got vld=%b extra_cycles=%0d acc=%0d, want 1 0 9",
                  out_valid, waited, acc_out);
      else n_pass++;
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_basic();
      test_len_zero();
      test_stall();
      test_overflow();
      test_start_ignored();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
